// File: rtl/des_pkg.sv
// des_pkg: shared definitions for the DES key-expander arbiter.
//   DES_KEY_W  - width of a DES key
//   DES_KX_LAT - cycles from the expander's key-load pulse to its "key ok"
//   des_state_e - arbiter FSM state encoding
package des_pkg;

  localparam int DES_KEY_W  = 64;
  localparam int DES_KX_LAT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_OWN  = 2'd3
  } des_state_e;

endpackage

// File: rtl/des_rr_arb.sv
// des_rr_arb: combinational round-robin picker.
// Ports:
//   req_i  - request vector
//   ptr_i  - highest-priority index for this pick
//   gnt_o  - one-hot winner (first set bit at or after ptr_i, wrapping)
//   idx_o  - binary index of the winner
//   any_o  - at least one request is set
module des_rr_arb
  import des_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      // Walk the ring starting at the pointer; modulo keeps non-power-of-2 NREQ in range.
      cand = IW'((int'(ptr_i) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        idx_o        = cand;
        gnt_o[cand]  = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/des_key_arb.sv
// des_key_arb: shares one DES key-expansion engine among NREQ requesters.
// Requests are served round-robin; a request whose key is already expanded
// is granted straight from the cache, otherwise the key is loaded into the
// expander and the grant follows its "key ok".
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_req          - per-requester request (held until granted and while owning)
//   i_key          - per-requester 64-bit keys, requester n at [64n+63:64n]
//   i_rel          - per-requester release pulse (honoured only for the owner in OWN)
//   o_gnt          - one-hot grant; round keys valid for the owner while high
//   o_kx_key       - key presented to the expander
//   o_kx_key_en    - one-cycle key-load pulse to the expander
//   i_kx_ok        - expander "all round keys valid"
//   o_busy         - FSM not in IDLE
//   o_hit          - one-cycle pulse when a grant is served from cache
//
// state | meaning
// IDLE  | waiting for a request; picks the round-robin winner
// LOAD  | key-load pulse to the expander, cache invalid
// WAIT  | expansion in progress; first cycle ignores i_kx_ok
// OWN   | winner holds the round keys until release or request drop
module des_key_arb
  import des_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter bit REUSE = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NREQ-1:0]           i_req,
  input  logic [DES_KEY_W*NREQ-1:0] i_key,
  input  logic [NREQ-1:0]           i_rel,
  output logic [NREQ-1:0]           o_gnt,
  output logic [DES_KEY_W-1:0]      o_kx_key,
  output logic                      o_kx_key_en,
  input  logic                      i_kx_ok,
  output logic                      o_busy,
  output logic                      o_hit
);

  localparam int            IW   = $clog2(NREQ);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  des_state_e            state_q;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         idx_q;
  logic [DES_KEY_W-1:0]  key_q;
  logic [DES_KEY_W-1:0]  cache_key_q;
  logic                  cache_vld_q;
  logic                  first_q;

  logic [NREQ-1:0]       arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic [DES_KEY_W-1:0]  req_key;
  logic [NREQ-1:0]       own_oh;
  logic                  owner_req;
  logic                  owner_rel;
  logic                  cache_hit;

  des_rr_arb #(.NREQ(NREQ)) u_rr (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign req_key   = i_key[arb_idx*DES_KEY_W +: DES_KEY_W];
  assign own_oh    = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
  assign owner_req = |(i_req & own_oh);
  assign owner_rel = |(i_rel & own_oh);
  assign cache_hit = (REUSE != 1'b0) && cache_vld_q && (req_key == cache_key_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      key_q       <= '0;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      first_q     <= 1'b0;
      o_gnt       <= '0;
      o_kx_key    <= '0;
      o_kx_key_en <= 1'b0;
      o_busy      <= 1'b0;
      o_hit       <= 1'b0;
    end else begin
      o_kx_key_en <= 1'b0;
      o_hit       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            idx_q  <= arb_idx;
            key_q  <= req_key;
            o_busy <= 1'b1;
            if (cache_hit) begin
              state_q <= ST_OWN;
              o_gnt   <= arb_gnt;
              o_hit   <= 1'b1;
            end else begin
              // Expander contents become stale the moment a new load starts.
              state_q     <= ST_LOAD;
              o_kx_key    <= req_key;
              o_kx_key_en <= 1'b1;
              cache_vld_q <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          state_q <= ST_WAIT;
          first_q <= 1'b1;
        end
        ST_WAIT: begin
          first_q <= 1'b0;
          // A stale "ok" from a previous key may still be visible in the first cycle.
          if (!first_q && i_kx_ok) begin
            cache_key_q <= key_q;
            cache_vld_q <= 1'b1;
            if (owner_req) begin
              state_q <= ST_OWN;
              o_gnt   <= own_oh;
            end else begin
              state_q <= ST_IDLE;
              o_busy  <= 1'b0;
            end
          end
        end
        ST_OWN: begin
          if (owner_rel || !owner_req) begin
            state_q <= ST_IDLE;
            o_gnt   <= '0;
            o_busy  <= 1'b0;
            ptr_q   <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_arb.sv
// Testbench for des_key_arb: a behavioural key expander, a reference model of
// the arbitration/cache rules, and a scoreboard monitor that checks every
// key load and grant the DUT presents.
module tb_des_key_arb;
  import des_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT (REUSE=1)
  logic [NREQ-1:0]      i_req = '0;
  logic [NREQ-1:0]      i_rel = '0;
  logic [63:0]          keys [NREQ];
  logic [64*NREQ-1:0]   i_key;
  logic [NREQ-1:0]      o_gnt;
  logic [63:0]          o_kx_key;
  logic                 o_kx_key_en, o_busy, o_hit;

  // Second DUT (REUSE=0)
  logic [NREQ-1:0]      nr_req = '0;
  logic [NREQ-1:0]      nr_rel = '0;
  logic [64*NREQ-1:0]   nr_key;
  logic [NREQ-1:0]      nr_gnt;
  logic [63:0]          nr_kx_key;
  logic                 nr_kx_key_en, nr_busy, nr_hit;

  // Behavioural expanders, index 0 for the main DUT, 1 for the REUSE=0 DUT
  logic [63:0] kx_key [2];
  logic        kx_en  [2];
  logic        kx_ok  [2] = '{1'b0, 1'b0};
  int          kx_cnt [2] = '{0, 0};
  logic [47:0] kx_rk1 [2];

  always_comb begin
    i_key = '0;
    for (int n = 0; n < NREQ; n++) i_key[n*64 +: 64] = keys[n];
  end
  assign nr_key = {192'd0, 64'h0E329232EA6D0D73};

  assign kx_key[0] = o_kx_key;
  assign kx_key[1] = nr_kx_key;
  assign kx_en[0]  = o_kx_key_en;
  assign kx_en[1]  = nr_kx_key_en;

  des_key_arb #(.NREQ(NREQ), .REUSE(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_key(i_key), .i_rel(i_rel),
    .o_gnt(o_gnt), .o_kx_key(o_kx_key), .o_kx_key_en(o_kx_key_en),
    .i_kx_ok(kx_ok[0]), .o_busy(o_busy), .o_hit(o_hit)
  );

  des_key_arb #(.NREQ(NREQ), .REUSE(1'b0)) u_dut_nr (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(nr_req), .i_key(nr_key), .i_rel(nr_rel),
    .o_gnt(nr_gnt), .o_kx_key(nr_kx_key), .o_kx_key_en(nr_kx_key_en),
    .i_kx_ok(kx_ok[1]), .o_busy(nr_busy), .o_hit(nr_hit)
  );

  // DES key schedule, round 1 only: PC-1, rotate C and D left by one, PC-2.
  localparam int PC1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                              10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                              63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                              14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                              23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                              41,52,31,37,47,55,30,40,51,45,33,48,
                              44,49,39,56,34,53,46,42,50,36,29,32};

  function automatic logic [47:0] des_rk1(input logic [63:0] k);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] rk;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
    c = cd[55:28];
    d = cd[27:0];
    c = {c[26:0], c[27]};
    d = {d[26:0], d[27]};
    cd = {c, d};
    for (int i = 0; i < 48; i++) rk[47-i] = cd[56-PC2[i]];
    return rk;
  endfunction

  // Key ok drops on the load edge and rises DES_KX_LAT cycles after the pulse.
  always @(posedge clk) begin
    for (int e = 0; e < 2; e++) begin
      if (kx_en[e]) begin
        kx_cnt[e] <= DES_KX_LAT - 1;
        kx_ok[e]  <= 1'b0;
        kx_rk1[e] <= des_rk1(kx_key[e]);
      end else if (kx_cnt[e] > 0) begin
        kx_cnt[e] <= kx_cnt[e] - 1;
        if (kx_cnt[e] == 1) kx_ok[e] <= 1'b1;
      end
    end
  end

  // Checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int idx; bit hit; int cyc; } gexp_t;
  typedef struct { logic [63:0] key; int cyc; } lexp_t;
  gexp_t gq[$];
  lexp_t lq[$];

  // Reference model: rr pointer and cached key
  int          m_ptr  = 0;
  bit          m_cvld = 1'b0;
  logic [63:0] m_ckey = '0;

  function automatic int model_pick(input logic [NREQ-1:0] pend);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (m_ptr + i) % NREQ;
      if (pend[j]) return j;
    end
    return -1;
  endfunction

  // Scoreboard monitor
  logic [NREQ-1:0] prev_gnt = '0;
  lexp_t le;
  gexp_t ge;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      if (o_kx_key_en) begin
        if (lq.size() == 0) chk("load_unexpected", 64'(lq.size()), 64'd1);
        else begin
          le = lq.pop_front();
          chk("load_key", o_kx_key, le.key);
          chk("load_cycle", 64'(cyc), 64'(le.cyc));
        end
      end
      if (o_gnt != '0 && prev_gnt == '0) begin
        if (gq.size() == 0) chk("gnt_unexpected", 64'(gq.size()), 64'd1);
        else begin
          ge = gq.pop_front();
          chk("gnt_onehot", 64'(o_gnt), 64'd1 << ge.idx);
          chk("gnt_hit", 64'(o_hit), 64'(ge.hit));
          chk("gnt_cycle", 64'(cyc), 64'(ge.cyc));
        end
      end else if (o_hit) begin
        chk("hit_stray", 64'(o_hit), 64'd0);
      end
      prev_gnt = o_gnt;
    end
  end

  int nr_loads = 0;
  int nr_hits  = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (nr_kx_key_en) nr_loads++;
      if (nr_hit) nr_hits++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int w, output bit got);
    got = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (o_gnt[w]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("gnt_timeout", 64'(got), 64'd1);
  endtask

  // Raise a request mask and serve every requester in it, predicting order,
  // cache hits and latency from the model.
  task automatic serve_batch(input logic [NREQ-1:0] mask, input int hmin, input int hmax);
    logic [NREQ-1:0] pend;
    int    base, w, r;
    bit    hit, got;
    gexp_t g;
    lexp_t l;
    pend  = mask;
    i_req = i_req | mask;
    base  = cyc;
    while (pend != '0) begin
      w   = model_pick(pend);
      hit = m_cvld && (keys[w] == m_ckey);
      g.idx = w; g.hit = hit; g.cyc = base + (hit ? 1 : 18);
      gq.push_back(g);
      if (!hit) begin
        l.key = keys[w]; l.cyc = base + 1;
        lq.push_back(l);
        m_cvld = 1'b1;
        m_ckey = keys[w];
      end
      wait_gnt(w, got);
      if (!got) begin
        i_req = '0;
        i_rel = '0;
        return;
      end
      repeat ($urandom_range(hmax, hmin)) tick();
      r = cyc;
      i_rel[w] = 1'b1;
      if ($urandom_range(1, 0) == 1) i_req[w] = 1'b0;
      tick();
      i_rel    = '0;
      i_req[w] = 1'b0;
      m_ptr    = (w + 1) % NREQ;
      pend[w]  = 1'b0;
      base     = r + 1;
    end
    tick();
    tick();
  endtask

  logic [63:0] pool [3];

  initial begin
    int    base, g1, r;
    lexp_t l;
    logic [NREQ-1:0] mask;

    for (int n = 0; n < NREQ; n++) keys[n] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(o_gnt), 64'd0);
    chk("rst_kx_key", o_kx_key, 64'd0);
    chk("rst_kx_en", 64'(o_kx_key_en), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_hit", 64'(o_hit), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single miss with the classic DES example key
    keys[0] = 64'h133457799BBCDFF1;
    serve_batch(4'b0001, 1, 1);
    chk("round_key1", 64'(kx_rk1[0]), 64'h1B02EFFC7072);

    // Cache hit from a different requester
    keys[2] = 64'h133457799BBCDFF1;
    serve_batch(4'b0100, 1, 2);

    // Bring the pointer back to 0, then all four requesters with distinct keys
    keys[3] = 64'hFEDCBA9876543210;
    serve_batch(4'b1000, 0, 1);
    keys[0] = 64'h1111111111111111;
    keys[1] = 64'h2222222222222222;
    keys[2] = 64'h3333333333333333;
    keys[3] = 64'h4444444444444444;
    serve_batch(4'b1111, 2, 2);

    // Abort during WAIT: no grant, cache still fills, re-request hits
    keys[1] = 64'hA5A50F0F12345678;
    i_req   = 4'b0010;
    base    = cyc;
    l.key = keys[1]; l.cyc = base + 1;
    lq.push_back(l);
    m_cvld = 1'b1;
    m_ckey = keys[1];
    repeat (6) tick();
    i_req[1] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!o_busy) break;
      tick();
    end
    chk("abort_idle", 64'(o_busy), 64'd0);
    chk("abort_nognt", 64'(o_gnt), 64'd0);
    tick();
    serve_batch(4'b0010, 0, 3);

    // Reset while waiting for the expander
    keys[3] = 64'h0123456789ABCDEF;
    i_req   = 4'b1000;
    base    = cyc;
    l.key = keys[3]; l.cyc = base + 1;
    lq.push_back(l);
    repeat (8) tick();
    rst_n = 1'b0;
    i_req = '0;
    #1;
    chk("midrst_gnt", 64'(o_gnt), 64'd0);
    chk("midrst_kx_key", o_kx_key, 64'd0);
    chk("midrst_kx_en", 64'(o_kx_key_en), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_hit", 64'(o_hit), 64'd0);
    repeat (3) tick();
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_cvld = 1'b0;
    tick();
    serve_batch(4'b0010, 0, 2);
    serve_batch(4'b1000, 0, 2);

    // Randomised batches drawing keys from a small pool so hits occur
    for (int p = 0; p < 3; p++) pool[p] = {$urandom, $urandom};
    for (int b = 0; b < 12; b++) begin
      mask = NREQ'($urandom_range(15, 1));
      for (int n = 0; n < NREQ; n++) keys[n] = pool[$urandom_range(2, 0)];
      serve_batch(mask, 0, 3);
    end

    // REUSE=0 instance: same key twice expands twice, never hits
    nr_req = 4'b0001;
    base   = cyc;
    g1     = -1;
    for (int n = 0; n < 60; n++) begin
      if (nr_gnt[0]) begin g1 = cyc; break; end
      tick();
    end
    chk("nr_lat1", 64'(g1), 64'(base + 18));
    repeat (2) tick();
    nr_rel = 4'b0001;
    nr_req = '0;
    tick();
    nr_rel = '0;
    nr_req = 4'b0001;
    base   = cyc;
    g1     = -1;
    for (int n = 0; n < 60; n++) begin
      if (nr_gnt[0]) begin g1 = cyc; break; end
      tick();
    end
    chk("nr_lat2", 64'(g1), 64'(base + 18));
    r = cyc;
    nr_rel = 4'b0001;
    tick();
    nr_rel = '0;
    nr_req = '0;
    repeat (3) tick();
    chk("nr_loads", 64'(nr_loads), 64'd2);
    chk("nr_hits", 64'(nr_hits), 64'd0);

    chk("load_queue_empty", 64'(lq.size()), 64'd0);
    chk("gnt_queue_empty", 64'(gq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/des_key_arb.md
Name: des_key_arb

Overview:
- Controller that shares one DES key-expansion engine (64-bit key in, 16 round keys out, ~16-cycle expansion) among NREQ requesters.
- Arbitrates requests round-robin and drives the engine's key load pulse. Waits for expansion to finish, then grants exclusive use of the round keys until the owner releases.
- Caches the currently expanded key, so a request for the same key is granted without re-expansion.
- Sits between the cipher round cores and the key expander.

Parameters:
- NREQ, 4, number of requesters (2..8)
- REUSE, 1, 1 = skip expansion when the requested key equals the loaded key

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  NREQ  per-requester request; held high until granted and while owning
- i_key  in  64*NREQ  per-requester key; requester n uses bits [64n+63:64n]; stable while i_req[n]=1
- i_rel  in  NREQ  per-requester release pulse, valid only while granted
- o_gnt  out  NREQ  one-hot grant; round keys are valid for the owner while high
- o_kx_key  out  64  key to the expander (registered)
- o_kx_key_en  out  1  one-cycle key-load pulse to the expander
- i_kx_ok  in  1  expander "key ok"; low during load, high once all 16 round keys are valid
- o_busy  out  1  high in any state other than IDLE
- o_hit  out  1  one-cycle pulse when a grant is served from cache

Behaviour:
- Reset (async, i_rst_n=0) clears:
  - outputs o_gnt, o_kx_key, o_kx_key_en, o_busy, o_hit to 0
  - internal state: state=IDLE, rr pointer=0, cache valid=0, loaded key=0
- Reset mid-operation aborts everything and invalidates the cache. The expander's own reset is separate; its result is ignored.
- FSM states: IDLE, LOAD, WAIT, OWN (all outputs registered).
- IDLE:
  - If any i_req bit is set, pick index = first set bit at or after the rr pointer, wrapping around.
  - Latch the index and its key.
  - If REUSE=1, cache valid, and the latched key equals the loaded key: go to OWN and pulse o_hit.
  - Otherwise go to LOAD.
- LOAD:
  - Exactly one cycle with o_kx_key_en=1 and o_kx_key=latched key.
  - Cache valid cleared in this cycle. Next state is WAIT.
- WAIT:
  - Ignore i_kx_ok in the first WAIT cycle; it is guaranteed low there.
  - On i_kx_ok=1: set loaded key = latched key, cache valid=1, go to OWN.
  - If the owner's i_req dropped meanwhile: still finish the expansion and mark the cache valid, but go to IDLE without granting.
- OWN:
  - o_gnt[index]=1.
  - On i_rel[index]=1 or i_req[index]=0: go to IDLE and set rr pointer = index+1 (mod NREQ).
  - o_gnt drops in the following cycle.
- Latency, request first seen in IDLE at cycle T:
  - Miss: o_kx_key_en at T+1, i_kx_ok at T+17, o_gnt at T+18.
  - Hit: o_gnt and o_hit at T+1.
- Back-to-back: release at T makes IDLE at T+1, so the next grant is at T+2 (hit) or T+19 (miss).
- i_rel on a non-owner index, or while not in OWN, is ignored.
- Multiple i_req bits set simultaneously: only the rr winner is served; the others wait with no starvation (pointer advances past the last owner).
- i_kx_ok already high on entry to WAIT is never accepted. i_kx_ok dropping while in OWN (foreign reload) is out of contract.

Decomposition:
- Shared package des_pkg holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, WAIT=2'd2, OWN=2'd3)
  - DES_KEY_W=64
  - DES_KX_LAT=16
- Natural sub-module: des_rr_arb, a combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, binary index, any.
- Remainder lives in des_key_arb.
- Bench instantiates the real expander and connects it to o_kx_key/o_kx_key_en/i_kx_ok.

Test Plan:
- Single miss: i_req[0]=1, key 0x133457799BBCDFF1 → o_kx_key_en pulse at T+1 with that key, o_gnt=4'b0001 at T+18, round key 1 from the expander = 0x1B02EFFC7072.
- Cache hit: after release, requester 2 asks for the same key → o_gnt=4'b0100 and o_hit=1 at T+1, no o_kx_key_en.
- Round-robin: i_req=4'b1111 with pointer 0 and distinct keys; each requester releases 2 cycles after grant → grant order 0,1,2,3, each a miss with o_kx_key_en.
- Abort: i_req[1] drops during WAIT → no grant, return to IDLE, cache holds key1; a later identical request hits.
- Reset mid-WAIT: i_rst_n low 3 cycles → all outputs 0; re-request of the previously cached key is a miss.
- REUSE=0: the same key requested twice → expansion both times, o_hit never asserts.
